// File: rtl/stage_memory_pkg.sv
// Shared types for the MEM stage: pipeline control structs, access widths and FSM states.
package stage_memory_pkg;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemWidth;
    logic       MemUnsigned;
  } MEM_Control_t;

  typedef struct packed {
    logic RegWrite;
    logic MemToReg;
  } WB_Control_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } RegisterIDs_t;

  localparam logic [1:0] MEMWIDTH_B = 2'b00;
  localparam logic [1:0] MEMWIDTH_H = 2'b01;
  localparam logic [1:0] MEMWIDTH_W = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  // Width code 11 has no legal alignment, so it always faults.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    case (width)
      MEMWIDTH_B: is_misaligned = 1'b0;
      MEMWIDTH_H: is_misaligned = addr_lo[0];
      MEMWIDTH_W: is_misaligned = (addr_lo != 2'b00);
      default:    is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
// Purely combinational; no latency and no flow control.
module mem_lane_align
  import stage_memory_pkg::*;
(
  input  logic [1:0]  st_width,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_byte_en,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_width,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_byte_en = 4'b1111;
    st_wdata   = st_data;
    case (st_width)
      MEMWIDTH_B: begin
        st_byte_en = 4'b0001 << st_addr_lo;
        st_wdata   = {4{st_data[7:0]}};
      end
      MEMWIDTH_H: begin
        st_byte_en = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = ld_rdata;
    case (ld_width)
      MEMWIDTH_B: ld_data = ld_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      MEMWIDTH_H: ld_data = ld_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// MEM stage: EX/MEM -> MEM/WB, running loads/stores over a req/ack port; non-memory ops take 1 cycle.
// Stalls upstream from a memory op's arrival until the ack cycle; misaligned ops fault without a request.
module stage_memory
  import stage_memory_pkg::*;
(
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  MEM_Control_t i_MEM_Control,
  input  WB_Control_t  i_WB_Control,
  input  RegisterIDs_t i_RegisterIDs,
  input  logic [31:0]  i_AluOutput,
  input  logic [31:0]  i_rs2Value,
  output WB_Control_t  o_WB_Control,
  output RegisterIDs_t o_RegisterIDs,
  output logic [31:0]  o_AluOutput,
  output logic [31:0]  o_MemReadData,
  output logic         o_Stall,
  output logic         o_DmemReq,
  output logic         o_DmemWe,
  output logic [31:0]  o_DmemAddr,
  output logic [3:0]   o_DmemByteEn,
  output logic [31:0]  o_DmemWData,
  input  logic         i_DmemAck,
  input  logic [31:0]  i_DmemRData,
  output logic         o_MisalignedFault,
  output logic [31:0]  o_FaultAddr
);

  state_t       state, state_nxt;
  logic         mem_op, misaligned, accept;
  logic [3:0]   st_byte_en;
  logic [31:0]  st_wdata, ld_data;

  logic [31:0]  lat_addr;
  logic [1:0]   lat_width;
  logic         lat_unsigned;
  logic         lat_store;
  WB_Control_t  lat_wb;
  RegisterIDs_t lat_ids;

  assign mem_op     = i_MEM_Control.MemRead | i_MEM_Control.MemWrite;
  assign misaligned = is_misaligned(i_MEM_Control.MemWidth, i_AluOutput[1:0]);
  assign accept     = mem_op & ~misaligned;

  mem_lane_align u_align (
    .st_width    (i_MEM_Control.MemWidth),
    .st_addr_lo  (i_AluOutput[1:0]),
    .st_data     (i_rs2Value),
    .st_byte_en  (st_byte_en),
    .st_wdata    (st_wdata),
    .ld_width    (lat_width),
    .ld_addr_lo  (lat_addr[1:0]),
    .ld_unsigned (lat_unsigned),
    .ld_rdata    (i_DmemRData),
    .ld_data     (ld_data)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_Stall   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          o_Stall   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        o_Stall = ~i_DmemAck;
        if (i_DmemAck) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_WB_Control      <= '0;
      o_RegisterIDs     <= '0;
      o_AluOutput       <= '0;
      o_MemReadData     <= '0;
      o_DmemReq         <= 1'b0;
      o_DmemWe          <= 1'b0;
      o_DmemAddr        <= '0;
      o_DmemByteEn      <= '0;
      o_DmemWData       <= '0;
      o_MisalignedFault <= 1'b0;
      o_FaultAddr       <= '0;
      lat_addr          <= '0;
      lat_width         <= '0;
      lat_unsigned      <= 1'b0;
      lat_store         <= 1'b0;
      lat_wb            <= '0;
      lat_ids           <= '0;
    end else begin
      o_MisalignedFault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr      <= i_AluOutput;
            lat_width     <= i_MEM_Control.MemWidth;
            lat_unsigned  <= i_MEM_Control.MemUnsigned;
            lat_store     <= i_MEM_Control.MemWrite;
            lat_wb        <= i_WB_Control;
            lat_ids       <= i_RegisterIDs;
            o_DmemReq     <= 1'b1;
            o_DmemWe      <= i_MEM_Control.MemWrite;
            o_DmemAddr    <= {i_AluOutput[31:2], 2'b00};
            o_DmemByteEn  <= st_byte_en;
            o_DmemWData   <= st_wdata;
            o_WB_Control  <= '0;
            o_MemReadData <= '0;
          end else if (mem_op) begin
            o_MisalignedFault <= 1'b1;
            o_FaultAddr       <= i_AluOutput;
            o_WB_Control      <= '0;
            o_MemReadData     <= '0;
          end else begin
            o_WB_Control  <= i_WB_Control;
            o_RegisterIDs <= i_RegisterIDs;
            o_AluOutput   <= i_AluOutput;
            o_MemReadData <= '0;
          end
        end
        S_WAIT: begin
          if (i_DmemAck) begin
            o_WB_Control  <= lat_wb;
            o_RegisterIDs <= lat_ids;
            o_AluOutput   <= lat_addr;
            o_MemReadData <= lat_store ? 32'd0 : ld_data;
            o_DmemReq     <= 1'b0;
          end else begin
            o_WB_Control  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: loads, stores, faults, reset mid-access and back-to-back ops.
module tb_stage_memory;
  import stage_memory_pkg::*;

  logic         i_Clock = 1'b0;
  logic         i_Reset;
  MEM_Control_t i_MEM_Control;
  WB_Control_t  i_WB_Control;
  RegisterIDs_t i_RegisterIDs;
  logic [31:0]  i_AluOutput, i_rs2Value;
  WB_Control_t  o_WB_Control;
  RegisterIDs_t o_RegisterIDs;
  logic [31:0]  o_AluOutput, o_MemReadData;
  logic         o_Stall, o_DmemReq, o_DmemWe;
  logic [31:0]  o_DmemAddr, o_DmemWData;
  logic [3:0]   o_DmemByteEn;
  logic         i_DmemAck;
  logic [31:0]  i_DmemRData;
  logic         o_MisalignedFault;
  logic [31:0]  o_FaultAddr;

  int errors = 0;
  int checks = 0;
  int stall_cycles;

  stage_memory dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_MEM_Control(i_MEM_Control), .i_WB_Control(i_WB_Control),
    .i_RegisterIDs(i_RegisterIDs), .i_AluOutput(i_AluOutput), .i_rs2Value(i_rs2Value),
    .o_WB_Control(o_WB_Control), .o_RegisterIDs(o_RegisterIDs),
    .o_AluOutput(o_AluOutput), .o_MemReadData(o_MemReadData), .o_Stall(o_Stall),
    .o_DmemReq(o_DmemReq), .o_DmemWe(o_DmemWe), .o_DmemAddr(o_DmemAddr),
    .o_DmemByteEn(o_DmemByteEn), .o_DmemWData(o_DmemWData),
    .i_DmemAck(i_DmemAck), .i_DmemRData(i_DmemRData),
    .o_MisalignedFault(o_MisalignedFault), .o_FaultAddr(o_FaultAddr)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] width, input logic uns,
                       input logic regwrite, input logic [4:0] rd_id,
                       input logic [31:0] alu, input logic [31:0] rs2);
    i_MEM_Control = '{MemRead: rd, MemWrite: wr, MemWidth: width, MemUnsigned: uns};
    i_WB_Control  = '{RegWrite: regwrite, MemToReg: rd};
    i_RegisterIDs = '{rs1: 5'd1, rs2: 5'd2, rd: rd_id};
    i_AluOutput   = alu;
    i_rs2Value    = rs2;
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  // Load with ack in the first WAIT cycle; on return the result is in MEM/WB.
  task automatic do_load(input string tag, input logic [1:0] width, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    drive(1'b1, 1'b0, width, uns, 1'b1, 5'd7, addr, 32'h0);
    #1 chk({tag, "_stall_arrive"}, o_Stall, 1);
    step();
    chk({tag, "_req"}, o_DmemReq, 1);
    chk({tag, "_we"}, o_DmemWe, 0);
    chk({tag, "_addr"}, o_DmemAddr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, o_DmemByteEn, exp_be);
    chk({tag, "_bubble"}, o_WB_Control.RegWrite, 0);
    i_DmemAck = 1'b1;
    i_DmemRData = rdata;
    #1 chk({tag, "_stall_ack"}, o_Stall, 0);
    step();
    i_DmemAck = 1'b0;
    chk({tag, "_data"}, o_MemReadData, exp_data);
    chk({tag, "_regwrite"}, o_WB_Control.RegWrite, 1);
    chk({tag, "_rd"}, o_RegisterIDs.rd, 7);
    chk({tag, "_alu"}, o_AluOutput, addr);
    chk({tag, "_req_clear"}, o_DmemReq, 0);
  endtask

  initial begin
    i_Reset = 1'b1;
    i_DmemAck = 1'b0;
    i_DmemRData = 32'h0;
    drive(1'b0, 1'b0, MEMWIDTH_W, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #3;
    chk("rst_req", o_DmemReq, 0);
    chk("rst_regwrite", o_WB_Control.RegWrite, 0);
    chk("rst_memdata", o_MemReadData, 0);
    chk("rst_fault", o_MisalignedFault, 0);
    chk("rst_stall", o_Stall, 0);
    step();
    i_Reset = 1'b0;
    step();

    // ADD result passes through in one cycle, then LW follows with no lost cycle.
    drive(1'b0, 1'b0, MEMWIDTH_W, 1'b0, 1'b1, 5'd5, 32'h55, 32'h0);
    #1 chk("add_stall", o_Stall, 0);
    step();
    chk("add_alu", o_AluOutput, 32'h55);
    chk("add_regwrite", o_WB_Control.RegWrite, 1);
    chk("add_rd", o_RegisterIDs.rd, 5);
    chk("add_memdata", o_MemReadData, 0);
    do_load("lw", MEMWIDTH_W, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);

    // Back-to-back loads, each issued in the cycle after the previous ack.
    do_load("lb", MEMWIDTH_B, 1'b0, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", MEMWIDTH_B, 1'b1, 32'h103, 32'h80112233, 4'b1000, 32'h00000080);
    do_load("lh", MEMWIDTH_H, 1'b0, 32'h102, 32'h80112233, 4'b1100, 32'hFFFF8011);
    do_load("lhu", MEMWIDTH_H, 1'b1, 32'h100, 32'h80119233, 4'b0011, 32'h00009233);

    // Stray ack in IDLE.
    drive(1'b0, 1'b0, MEMWIDTH_W, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    i_DmemAck = 1'b1;
    i_DmemRData = 32'h12345678;
    #1 chk("idle_ack_stall", o_Stall, 0);
    step();
    i_DmemAck = 1'b0;
    chk("idle_ack_req", o_DmemReq, 0);
    chk("idle_ack_data", o_MemReadData, 0);

    // SB with ack 5 cycles after arrival; request fields must stay put while waiting.
    drive(1'b0, 1'b1, MEMWIDTH_B, 1'b0, 1'b0, 5'd0, 32'h201, 32'h000000A5);
    #1 chk("sb_stall_arrive", o_Stall, 1);
    stall_cycles = o_Stall ? 1 : 0;
    step();
    chk("sb_req", o_DmemReq, 1);
    chk("sb_we", o_DmemWe, 1);
    chk("sb_addr", o_DmemAddr, 32'h200);
    chk("sb_be", o_DmemByteEn, 4'b0010);
    chk("sb_wdata", o_DmemWData, 32'hA5A5A5A5);
    for (int k = 0; k < 4; k++) begin
      chk("sb_stall_wait", o_Stall, 1);
      if (o_Stall) stall_cycles++;
      step();
      chk("sb_hold_req", o_DmemReq, 1);
      chk("sb_hold_addr", o_DmemAddr, 32'h200);
      chk("sb_hold_be", o_DmemByteEn, 4'b0010);
      chk("sb_hold_wdata", o_DmemWData, 32'hA5A5A5A5);
      chk("sb_hold_bubble", o_WB_Control.RegWrite, 0);
    end
    i_DmemAck = 1'b1;
    #1 chk("sb_stall_ack", o_Stall, 0);
    step();
    i_DmemAck = 1'b0;
    chk("sb_stall_cycles", stall_cycles, 5);
    chk("sb_req_clear", o_DmemReq, 0);
    chk("sb_regwrite", o_WB_Control.RegWrite, 0);
    chk("sb_memdata", o_MemReadData, 0);

    // SH to upper half, with MemRead also set: must be treated as a store.
    drive(1'b1, 1'b1, MEMWIDTH_H, 1'b0, 1'b0, 5'd0, 32'h202, 32'h1234ABCD);
    step();
    chk("sh_we", o_DmemWe, 1);
    chk("sh_be", o_DmemByteEn, 4'b1100);
    chk("sh_wdata", o_DmemWData, 32'hABCDABCD);
    i_DmemAck = 1'b1;
    i_DmemRData = 32'hFFFFFFFF;
    step();
    i_DmemAck = 1'b0;
    chk("sh_memdata", o_MemReadData, 0);
    chk("sh_req_clear", o_DmemReq, 0);

    // Misaligned LW: no request, one-cycle fault pulse, address held.
    drive(1'b1, 1'b0, MEMWIDTH_W, 1'b0, 1'b1, 5'd9, 32'h102, 32'h0);
    #1 chk("mis_stall", o_Stall, 0);
    step();
    chk("mis_req", o_DmemReq, 0);
    chk("mis_fault", o_MisalignedFault, 1);
    chk("mis_faddr", o_FaultAddr, 32'h102);
    chk("mis_regwrite", o_WB_Control.RegWrite, 0);
    drive(1'b0, 1'b0, MEMWIDTH_W, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("mis_fault_pulse", o_MisalignedFault, 0);
    chk("mis_faddr_hold", o_FaultAddr, 32'h102);

    // Width code 11 faults even at an aligned address.
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 5'd9, 32'h500, 32'h0);
    #1 chk("ill_stall", o_Stall, 0);
    step();
    chk("ill_fault", o_MisalignedFault, 1);
    chk("ill_faddr", o_FaultAddr, 32'h500);
    chk("ill_req", o_DmemReq, 0);

    // Reset during WAIT, then a stray ack two cycles later.
    drive(1'b1, 1'b0, MEMWIDTH_W, 1'b0, 1'b1, 5'd3, 32'h300, 32'h0);
    step();
    chk("rw_req", o_DmemReq, 1);
    drive(1'b0, 1'b0, MEMWIDTH_W, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    i_Reset = 1'b1;
    #1;
    chk("rw_req_abort", o_DmemReq, 0);
    chk("rw_stall_abort", o_Stall, 0);
    step();
    i_Reset = 1'b0;
    step();
    i_DmemAck = 1'b1;
    i_DmemRData = 32'hCAFEF00D;
    #1 chk("rw_stall_ack", o_Stall, 0);
    step();
    i_DmemAck = 1'b0;
    chk("rw_req_after", o_DmemReq, 0);
    chk("rw_regwrite", o_WB_Control.RegWrite, 0);
    chk("rw_memdata", o_MemReadData, 0);

    // FSM back in IDLE: a fresh load is accepted normally.
    do_load("post_rst", MEMWIDTH_W, 1'b0, 32'h404, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
